// File: rtl/trackball_delta_reader.sv
// Turns free-running X/Y quadrature counts into saturating signed deltas
// accumulated between host reads, handed over on a 4-phase req/ack handshake.
module trackball_delta_reader #(
  parameter int CNT_W = 7,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic                    enable,
  input  logic        [CNT_W-1:0] cnt_x,
  input  logic        [CNT_W-1:0] cnt_y,
  input  logic                    rd_req,
  output logic                    rd_ack,
  output logic signed [OUT_W-1:0] dx,
  output logic signed [OUT_W-1:0] dy,
  output logic                    ovf_x,
  output logic                    ovf_y,
  output logic                    moved
);

  typedef enum logic {IDLE, ACK} state_e;

  state_e                  state_q, state_d;
  logic        [CNT_W-1:0] prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic signed [OUT_W-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic                    sticky_x_q, sticky_x_d, sticky_y_q, sticky_y_d;
  logic signed [OUT_W-1:0] dx_q, dx_d, dy_q, dy_d;
  logic                    ovf_x_q, ovf_x_d, ovf_y_q, ovf_y_d;
  logic                    rd_ack_q, rd_ack_d;
  logic                    moved_q, moved_d;

  logic signed [OUT_W:0]   step_x_eff, step_y_eff;
  logic signed [OUT_W:0]   sum_x, sum_y;
  logic signed [OUT_W-1:0] sat_x, sat_y;
  logic                    clamp_x, clamp_y;

  // Modular difference reinterpreted as signed, so a counter wrap is a +/-1 step.
  function automatic logic signed [OUT_W:0] step_ext(input logic [CNT_W-1:0] cnt,
                                                      input logic [CNT_W-1:0] prev);
    logic [CNT_W-1:0] diff;
    diff = cnt - prev;
    return {{(OUT_W+1-CNT_W){diff[CNT_W-1]}}, diff};
  endfunction

  function automatic logic sat_ovf(input logic signed [OUT_W:0] s);
    return s[OUT_W] ^ s[OUT_W-1];
  endfunction

  function automatic logic signed [OUT_W-1:0] sat_val(input logic signed [OUT_W:0] s);
    if (sat_ovf(s)) begin
      return s[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    end
    return s[OUT_W-1:0];
  endfunction

  always_comb begin
    step_x_eff = enable ? step_ext(cnt_x, prev_x_q) : '0;
    step_y_eff = enable ? step_ext(cnt_y, prev_y_q) : '0;
    sum_x      = {acc_x_q[OUT_W-1], acc_x_q} + step_x_eff;
    sum_y      = {acc_y_q[OUT_W-1], acc_y_q} + step_y_eff;
    sat_x      = sat_val(sum_x);
    sat_y      = sat_val(sum_y);
    clamp_x    = sat_ovf(sum_x);
    clamp_y    = sat_ovf(sum_y);

    state_d    = state_q;
    prev_x_d   = enable ? cnt_x : prev_x_q;
    prev_y_d   = enable ? cnt_y : prev_y_q;
    acc_x_d    = sat_x;
    acc_y_d    = sat_y;
    sticky_x_d = sticky_x_q | clamp_x;
    sticky_y_d = sticky_y_q | clamp_y;
    dx_d       = dx_q;
    dy_d       = dy_q;
    ovf_x_d    = ovf_x_q;
    ovf_y_d    = ovf_y_q;
    rd_ack_d   = rd_ack_q;
    moved_d    = (acc_x_q != '0) | (acc_y_q != '0);

    unique case (state_q)
      IDLE: begin
        if (rd_req) begin
          // Capture-cycle motion lands in the snapshot, not in the cleared accumulator.
          dx_d       = sat_x;
          dy_d       = sat_y;
          ovf_x_d    = sticky_x_q | clamp_x;
          ovf_y_d    = sticky_y_q | clamp_y;
          acc_x_d    = '0;
          acc_y_d    = '0;
          sticky_x_d = 1'b0;
          sticky_y_d = 1'b0;
          rd_ack_d   = 1'b1;
          state_d    = ACK;
        end
      end
      ACK: begin
        if (!rd_req) begin
          rd_ack_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= IDLE;
      prev_x_q   <= '0;
      prev_y_q   <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      sticky_x_q <= 1'b0;
      sticky_y_q <= 1'b0;
      dx_q       <= '0;
      dy_q       <= '0;
      ovf_x_q    <= 1'b0;
      ovf_y_q    <= 1'b0;
      rd_ack_q   <= 1'b0;
      moved_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_x_q   <= prev_x_d;
      prev_y_q   <= prev_y_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      sticky_x_q <= sticky_x_d;
      sticky_y_q <= sticky_y_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      ovf_x_q    <= ovf_x_d;
      ovf_y_q    <= ovf_y_d;
      rd_ack_q   <= rd_ack_d;
      moved_q    <= moved_d;
    end
  end

  assign rd_ack = rd_ack_q;
  assign dx     = dx_q;
  assign dy     = dy_q;
  assign ovf_x  = ovf_x_q;
  assign ovf_y  = ovf_y_q;
  assign moved  = moved_q;

endmodule

// File: tb/tb_trackball_delta_reader.sv
// Bench for trackball_delta_reader: directed scenarios plus random motion,
// compared every cycle against an integer-arithmetic reference model.
module tb_trackball_delta_reader;

  logic              clk = 1'b0;
  logic              clrn;
  logic              en;
  logic [6:0]        cx, cy;
  logic              req;
  logic              rd_ack;
  logic signed [7:0] dx, dy;
  logic              ovf_x, ovf_y, moved;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference model state
  int m_prev_x, m_prev_y, m_acc_x, m_acc_y, m_stk_x, m_stk_y;
  int m_dx, m_dy, m_ox, m_oy, m_ack, m_moved;

  trackball_delta_reader #(.CNT_W(7), .OUT_W(8)) dut (
    .clk    (clk),
    .clrn   (clrn),
    .enable (en),
    .cnt_x  (cx),
    .cnt_y  (cy),
    .rd_req (req),
    .rd_ack (rd_ack),
    .dx     (dx),
    .dy     (dy),
    .ovf_x  (ovf_x),
    .ovf_y  (ovf_y),
    .moved  (moved)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input int exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Count difference modulo 128, taken as the shortest signed move.
  function automatic int wrap_step(input int c, input int p);
    int d;
    d = (c - p) % 128;
    if (d < 0) d += 128;
    if (d >= 64) d -= 128;
    return d;
  endfunction

  function automatic int clampv(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  task automatic model_reset();
    m_prev_x = 0; m_prev_y = 0; m_acc_x = 0; m_acc_y = 0;
    m_stk_x = 0; m_stk_y = 0; m_dx = 0; m_dy = 0;
    m_ox = 0; m_oy = 0; m_ack = 0; m_moved = 0;
  endtask

  task automatic model_edge();
    int sx, sy, tx, ty, mv;
    sx = en ? wrap_step(int'(cx), m_prev_x) : 0;
    sy = en ? wrap_step(int'(cy), m_prev_y) : 0;
    mv = (m_acc_x != 0 || m_acc_y != 0) ? 1 : 0;
    tx = m_acc_x + sx;
    ty = m_acc_y + sy;
    if (m_ack == 0 && req) begin
      m_dx = clampv(tx);
      m_dy = clampv(ty);
      m_ox = (m_stk_x != 0 || tx != clampv(tx)) ? 1 : 0;
      m_oy = (m_stk_y != 0 || ty != clampv(ty)) ? 1 : 0;
      m_acc_x = 0; m_acc_y = 0; m_stk_x = 0; m_stk_y = 0;
      m_ack = 1;
    end else begin
      if (tx != clampv(tx)) m_stk_x = 1;
      if (ty != clampv(ty)) m_stk_y = 1;
      m_acc_x = clampv(tx);
      m_acc_y = clampv(ty);
      if (m_ack != 0 && !req) m_ack = 0;
    end
    if (en) begin
      m_prev_x = int'(cx);
      m_prev_y = int'(cy);
    end
    m_moved = mv;
  endtask

  task automatic compare_all();
    check("rd_ack", rd_ack, m_ack);
    check("dx", dx, m_dx);
    check("dy", dy, m_dy);
    check("ovf_x", ovf_x, m_ox);
    check("ovf_y", ovf_y, m_oy);
    check("moved", moved, m_moved);
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_read();
    req = 1'b1;
    cyc();
    check("ack_rise", rd_ack, 1);
    req = 1'b0;
    cyc();
    check("ack_fall", rd_ack, 0);
  endtask

  int wx[4] = '{126, 127, 0, 1};
  int wy[4] = '{1, 0, 127, 126};

  initial begin
    int d;
    clrn = 1'b0; en = 1'b0; cx = '0; cy = '0; req = 1'b0;
    model_reset();
    #12;
    check("rst_ack", rd_ack, 0);
    check("rst_dx", dx, 0);
    check("rst_dy", dy, 0);
    check("rst_ovf", {ovf_y, ovf_x}, 0);
    check("rst_moved", moved, 0);
    @(posedge clk); #1;
    clrn = 1'b1;

    // basic +5 on X
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      cx = 7'(i);
      cyc();
    end
    do_read();
    check("t1_dx", dx, 5);
    check("t1_dy", dy, 0);
    check("t1_ovf", {ovf_y, ovf_x}, 0);
    check("t1_moved", moved, 0);

    // wrap through 127/0 in both directions
    cx = 7'd65; cy = 7'd2; cyc();
    cx = 7'd125; cyc();
    do_read();
    for (int i = 0; i < 4; i++) begin
      cx = 7'(wx[i]);
      cy = 7'(wy[i]);
      cyc();
    end
    do_read();
    check("wrap_dx", dx, 4);
    check("wrap_dy", dy, -4);

    // saturation and sticky overflow
    repeat (200) begin
      cx = cx + 7'd1;
      cyc();
    end
    do_read();
    check("sat_dx", dx, 127);
    check("sat_ovf_x", ovf_x, 1);
    do_read();
    check("sat2_dx", dx, 0);
    check("sat2_ovf_x", ovf_x, 0);

    // motion in the capture cycle
    repeat (3) begin
      cx = cx + 7'd1;
      cyc();
    end
    cx = cx + 7'd1;
    req = 1'b1;
    cyc();
    req = 1'b0;
    cyc();
    check("simul_dx", dx, 4);
    do_read();
    check("simul_next_dx", dx, 0);

    // held request: single capture, motion accumulates behind it
    req = 1'b1;
    cyc();
    for (int i = 0; i < 9; i++) begin
      if (i < 6) cx = cx + 7'd1;
      cyc();
      check("hold_dx", dx, 0);
      check("hold_ack", rd_ack, 1);
    end
    req = 1'b0;
    cyc();
    check("hold_ack_fall", rd_ack, 0);
    do_read();
    check("hold_next_dx", dx, 6);

    // enable gating
    en = 1'b0;
    cx = cx + 7'd3;
    repeat (3) cyc();
    check("gate_moved", moved, 0);
    en = 1'b1;
    cyc();
    cyc();
    check("gate_moved_after", moved, 1);
    do_read();
    check("gate_dx", dx, 3);

    // random motion and request traffic
    for (int i = 0; i < 400; i++) begin
      en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) d = int'($urandom_range(0, 126)) - 63;
      else if (i < 200) d = int'($urandom_range(0, 12)) - 3;
      else d = 3 - int'($urandom_range(0, 12));
      cx = cx + 7'(d);
      cy = cy - 7'(d / 2) + 7'($urandom_range(0, 2));
      if ($urandom_range(0, 5) == 0) req = ~req;
      cyc();
    end
    req = 1'b0;
    cyc();
    cyc();

    // asynchronous reset during ACK
    cx = cx + 7'd2;
    cyc();
    req = 1'b1;
    cyc();
    check("mid_ack", rd_ack, 1);
    #2;
    clrn = 1'b0;
    #1;
    check("arst_ack", rd_ack, 0);
    check("arst_dx", dx, 0);
    check("arst_dy", dy, 0);
    check("arst_ovf", {ovf_y, ovf_x}, 0);
    check("arst_moved", moved, 0);
    model_reset();
    req = 1'b0; cx = '0; cy = '0;
    #2;
    clrn = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cx = cx - 7'd1;
      cyc();
    end
    do_read();
    check("post_rst_dx", dx, -7);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
